// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and pending-count delta encoding for the
//               scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_READ   = 2;
    localparam int MAX_NUM_READ       = 4;

    // Net change applied to the pending counter in one cycle.
    typedef enum logic [1:0] {
        DELTA_NONE = 2'b00,
        DELTA_INC  = 2'b01,
        DELTA_DEC  = 2'b10
    } pend_delta_e;

    // Increment and decrement in the same cycle cancel (they touch different registers).
    function automatic pend_delta_e pend_delta(input logic inc, input logic dec);
        pend_delta_e d;
        d = DELTA_NONE;
        if (inc && !dec) begin
            d = DELTA_INC;
        end else if (dec && !inc) begin
            d = DELTA_DEC;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Read, write and scoreboard bus of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = regfile_pkg::DEFAULT_NUM_READ
);
    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] ReadRegister;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] ReadData;
    logic [NUM_READ-1:0]                 ReadBusy;
    logic [ADDR_WIDTH-1:0]               WriteRegister;
    logic [DATA_WIDTH-1:0]               WriteData;
    logic                                RegWrite;
    logic [ADDR_WIDTH-1:0]               IssueRegister;
    logic                                IssueValid;
    logic                                Flush;
    logic [ADDR_WIDTH:0]                 PendingCount;

    // Decode/writeback side.
    modport master (
        output ReadRegister, WriteRegister, WriteData, RegWrite,
               IssueRegister, IssueValid, Flush,
        input  ReadData, ReadBusy, PendingCount
    );

    // Register file side.
    modport slave (
        input  ReadRegister, WriteRegister, WriteData, RegWrite,
               IssueRegister, IssueValid, Flush,
        output ReadData, ReadBusy, PendingCount
    );
endinterface
`default_nettype wire

// File: rtl/regfile_entry.sv
`default_nettype none
// ============================================================================
// Module      : regfile_entry
// Description : One architectural register with its pending-write busy bit.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_entry #(
    parameter int DATA_WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  set_i,
    input  logic                  clr_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o
);
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  busy_d;

    // Flush beats everything; a new issue beats the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = 1'b0;
        end else if (set_i) begin
            busy_d = 1'b1;
        end else if (clr_i) begin
            busy_d = 1'b0;
        end
    end

    // Storage and busy bit, both cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (we_i) begin
                data_q <= wdata_i;
            end
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Multi-read-port register file with write-through bypass,
//               hardwired zero register and pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = DEFAULT_NUM_READ,
    parameter int ZERO_REG   = (2**ADDR_WIDTH) - 1,
    parameter int BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int                    DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] w_entry_data [DEPTH];
    logic [DEPTH-1:0]      w_busy;
    logic                  w_set_valid;
    logic                  w_write_valid;
    logic                  w_inc;
    logic                  w_dec;
    pend_delta_e           w_delta;
    logic [ADDR_WIDTH:0]   pending_q;
    logic [ADDR_WIDTH:0]   pending_d;

    // The zero register is excluded from both writes and issues.
    assign w_set_valid   = bus.IssueValid && (bus.IssueRegister != ZERO_ADDR);
    assign w_write_valid = bus.RegWrite   && (bus.WriteRegister != ZERO_ADDR);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            if (i == ZERO_REG) begin : g_zero
                assign w_entry_data[i] = '0;
                assign w_busy[i]       = 1'b0;
            end else begin : g_reg
                regfile_entry #(
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_entry (
                    .clk     (clk),
                    .reset   (reset),
                    .we_i    (w_write_valid && (bus.WriteRegister == ADDR_WIDTH'(i))),
                    .wdata_i (bus.WriteData),
                    .set_i   (w_set_valid && (bus.IssueRegister == ADDR_WIDTH'(i))),
                    .clr_i   (w_write_valid && (bus.WriteRegister == ADDR_WIDTH'(i))),
                    .flush_i (bus.Flush),
                    .data_o  (w_entry_data[i]),
                    .busy_o  (w_busy[i])
                );
            end
        end

        // Read muxes; a matching same-cycle write is forwarded and its busy bit hidden.
        for (genvar k = 0; k < NUM_READ; k++) begin : g_read
            logic [ADDR_WIDTH-1:0] w_addr;
            logic                  w_hit;
            assign w_addr = bus.ReadRegister[k];
            assign w_hit  = (BYPASS != 0) && !reset && w_write_valid &&
                            (bus.WriteRegister == w_addr);
            assign bus.ReadData[k] = w_hit ? bus.WriteData : w_entry_data[w_addr];
            assign bus.ReadBusy[k] = w_hit ? 1'b0 : w_busy[w_addr];
        end
    endgenerate

    // Incremental pending count tracking the busy-bit population.
    always_comb begin
        w_inc     = w_set_valid && !w_busy[bus.IssueRegister];
        w_dec     = w_write_valid && w_busy[bus.WriteRegister] &&
                    !(w_set_valid && (bus.IssueRegister == bus.WriteRegister));
        w_delta   = pend_delta(w_inc, w_dec);
        pending_d = pending_q;
        if (bus.Flush) begin
            pending_d = '0;
        end else begin
            case (w_delta)
                DELTA_INC: pending_d = pending_q + (ADDR_WIDTH+1)'(1);
                DELTA_DEC: pending_d = pending_q - (ADDR_WIDTH+1)'(1);
                default:   pending_d = pending_q;
            endcase
        end
    end

    // Pending count register, updated on the same edge as the busy bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.PendingCount = pending_q;
endmodule
`default_nettype wire
